// File: rtl/signal_select_scanner_pkg.sv
// Shared definitions for the signal select scanner: CSR map, field positions,
// FSM state encoding and default widths.
package signal_select_scanner_pkg;

    localparam int SEL_W_DEF = 8;
    localparam int CNT_W_DEF = 32;

    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_PERIOD   = 2'd1;
    localparam logic [1:0] ADDR_SCAN_MAX = 2'd2;
    localparam logic [1:0] ADDR_STATUS   = 2'd3;

    localparam int CTRL_SCAN_EN_BIT = 0;
    localparam int CTRL_GO_BIT      = 1;
    localparam int CTRL_SEL_LSB     = 8;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_SEL_LSB  = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STROBE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/signal_select_scanner_tick_gen.sv
// Period counter producing a one-cycle scan tick every max(period,1) enabled cycles.
module scan_tick_gen #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [CNT_W-1:0] period,
    output logic             tick
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] last;

    // A period of zero is treated as one, so the tick fires every cycle.
    assign last = (period == '0) ? '0 : period - CNT_W'(1);
    assign tick = enable && (count == last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || !enable || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/signal_select_scanner.sv
// CSR-controlled selector scanner: issues single-cycle PIO writes carrying either
// a manually requested selector or the next value of a periodic scan sequence.
module signal_select_scanner
    import signal_select_scanner_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [1:0]       m_address,
    output logic             m_chipselect,
    output logic             m_write_n,
    output logic [31:0]      m_writedata,
    output logic [SEL_W-1:0] cur_sel,
    output logic             busy
);

    scan_state_t      state;
    logic             scan_en;
    logic [SEL_W-1:0] manual_sel;
    logic [CNT_W-1:0] period;
    logic [SEL_W-1:0] scan_max;
    logic             manual_pending;
    logic [SEL_W-1:0] manual_req_sel;
    logic             scan_pending;
    logic [SEL_W-1:0] scan_idx;
    logic [SEL_W-1:0] strobe_sel;

    logic             csr_wr;
    logic             ctrl_wr;
    logic             go_wr;
    logic             scan_off_wr;
    logic [SEL_W-1:0] wr_sel;
    logic             tick;
    logic             issue_manual;
    logic             issue_scan;
    logic [SEL_W-1:0] scan_next;
    logic [SEL_W-1:0] issue_sel;

    assign csr_wr      = chipselect && !write_n;
    assign ctrl_wr     = csr_wr && (address == ADDR_CTRL);
    assign go_wr       = ctrl_wr && writedata[CTRL_GO_BIT];
    assign scan_off_wr = ctrl_wr && !writedata[CTRL_SCAN_EN_BIT];
    assign wr_sel      = writedata[CTRL_SEL_LSB +: SEL_W];

    scan_tick_gen #(
        .CNT_W (CNT_W)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (scan_en),
        .clear   (go_wr || scan_off_wr),
        .period  (period),
        .tick    (tick)
    );

    // Manual requests win; a scan request being switched off this edge is not issued.
    assign issue_manual = (state == ST_IDLE) && manual_pending;
    assign issue_scan   = (state == ST_IDLE) && !manual_pending && scan_pending && !scan_off_wr;
    assign scan_next    = (scan_idx >= scan_max) ? '0 : scan_idx + SEL_W'(1);
    assign issue_sel    = issue_manual ? manual_req_sel : scan_next;

    assign busy      = (state == ST_STROBE) || manual_pending || scan_pending;
    assign m_address = 2'b00;

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:     readdata = (32'(manual_sel) << CTRL_SEL_LSB) |
                                      (32'(scan_en) << CTRL_SCAN_EN_BIT);
            ADDR_PERIOD:   readdata = 32'(period);
            ADDR_SCAN_MAX: readdata = 32'(scan_max);
            ADDR_STATUS:   readdata = (32'(cur_sel) << STATUS_SEL_LSB) |
                                      (32'(busy) << STATUS_BUSY_BIT);
            default:       readdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_en        <= 1'b0;
            manual_sel     <= '0;
            period         <= '0;
            scan_max       <= '0;
            manual_pending <= 1'b0;
            manual_req_sel <= '0;
            scan_pending   <= 1'b0;
            scan_idx       <= '0;
        end else begin
            if (ctrl_wr) begin
                scan_en    <= writedata[CTRL_SCAN_EN_BIT];
                manual_sel <= wr_sel;
            end
            if (csr_wr && (address == ADDR_PERIOD)) begin
                period <= writedata[CNT_W-1:0];
            end
            if (csr_wr && (address == ADDR_SCAN_MAX)) begin
                scan_max <= writedata[SEL_W-1:0];
            end

            if (go_wr) begin
                manual_pending <= 1'b1;
                manual_req_sel <= wr_sel;
            end else if (issue_manual) begin
                manual_pending <= 1'b0;
            end

            if (scan_off_wr) begin
                scan_pending <= 1'b0;
            end else if (tick) begin
                scan_pending <= 1'b1;
            end else if (issue_scan) begin
                scan_pending <= 1'b0;
            end

            // A manual selection re-seeds the scan sequence from that point.
            if (go_wr) begin
                scan_idx <= wr_sel;
            end else if (issue_scan) begin
                scan_idx <= scan_next;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_writedata  <= '0;
            strobe_sel   <= '0;
            cur_sel      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue_manual || issue_scan) begin
                        state        <= ST_STROBE;
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        m_writedata  <= 32'(issue_sel);
                        strobe_sel   <= issue_sel;
                    end
                end
                ST_STROBE: begin
                    state        <= ST_IDLE;
                    m_chipselect <= 1'b0;
                    m_write_n    <= 1'b1;
                    cur_sel      <= strobe_sel;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_signal_select_scanner.sv
// Randomised bench for signal_select_scanner: a cycle-level reference model is
// compared every cycle, with directed scenarios pinning exact strobe timing.
module tb_signal_select_scanner;
    import signal_select_scanner_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic [7:0]  cur_sel;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;
    logic [31:0] strobe_data[$];
    int          strobe_cyc[$];

    signal_select_scanner #(.SEL_W(8), .CNT_W(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .cur_sel      (cur_sel),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // Reference state: register contents, one request slot per source, strobe in flight.
    logic [31:0] md_period;
    longint      md_cnt;
    int          md_scan_max, md_idx, md_msel, md_man_sel, md_strobe_sel, md_cur, md_wdata;
    bit          md_scan_en, md_man_pend, md_scan_pend, md_strobe;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        md_period = '0; md_cnt = 0; md_scan_max = 0; md_idx = 0; md_msel = 0;
        md_man_sel = 0; md_strobe_sel = 0; md_cur = 0; md_wdata = 0;
        md_scan_en = 0; md_man_pend = 0; md_scan_pend = 0; md_strobe = 0;
    endtask

    task automatic modelStep();
        bit wr, ctrl, go, off, tick, iss_m, iss_s;
        int wsel, nxt;
        longint steps;
        wr    = chipselect && !write_n;
        ctrl  = wr && (address == 2'd0);
        go    = ctrl && writedata[1];
        off   = ctrl && !writedata[0];
        wsel  = int'(writedata[15:8]);
        steps = (md_period == 0) ? 1 : longint'(md_period);
        tick  = md_scan_en && (md_cnt == steps - 1);
        iss_m = !md_strobe && md_man_pend;
        iss_s = !md_strobe && !md_man_pend && md_scan_pend && !off;
        nxt   = (md_idx >= md_scan_max) ? 0 : md_idx + 1;

        if (md_strobe) md_cur = md_strobe_sel;
        md_strobe = iss_m || iss_s;
        if (iss_m) begin md_strobe_sel = md_man_sel; md_wdata = md_man_sel; end
        else if (iss_s) begin md_strobe_sel = nxt; md_wdata = nxt; end

        if (go) md_idx = wsel;
        else if (iss_s) md_idx = nxt;

        if (!md_scan_en || go || off || tick) md_cnt = 0;
        else md_cnt = md_cnt + 1;

        if (off) md_scan_pend = 0;
        else if (tick) md_scan_pend = 1;
        else if (iss_s) md_scan_pend = 0;

        if (go) begin md_man_pend = 1; md_man_sel = wsel; end
        else if (iss_m) md_man_pend = 0;

        if (ctrl) begin md_scan_en = writedata[0]; md_msel = wsel; end
        if (wr && address == 2'd1) md_period = writedata;
        if (wr && address == 2'd2) md_scan_max = int'(writedata[7:0]);
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) modelReset();
        else modelStep();
    end

    always @(negedge clk) begin
        logic [31:0] exp_rd;
        bit exp_busy;
        exp_busy = md_strobe || md_man_pend || md_scan_pend;
        case (address)
            2'd0:    exp_rd = (32'(md_msel) << 8) | 32'(md_scan_en);
            2'd1:    exp_rd = md_period;
            2'd2:    exp_rd = 32'(md_scan_max);
            default: exp_rd = (32'(md_cur) << 8) | 32'(exp_busy);
        endcase
        checkOutput("m_chipselect", 32'(m_chipselect), 32'(md_strobe));
        checkOutput("m_write_n", 32'(m_write_n), 32'(!md_strobe));
        checkOutput("m_writedata", m_writedata, 32'(md_wdata));
        checkOutput("m_address", 32'(m_address), 32'd0);
        checkOutput("cur_sel", 32'(cur_sel), 32'(md_cur));
        checkOutput("busy", 32'(busy), 32'(exp_busy));
        checkOutput("readdata", readdata, exp_rd);
        if (reset_n && m_chipselect) begin
            strobe_data.push_back(m_writedata);
            strobe_cyc.push_back(cycle);
        end
    end

    // Drive one bus cycle; values are sampled at the next rising edge.
    task automatic applyStimulus(input logic cs, input logic wn, input logic [1:0] addr, input logic [31:0] data);
        chipselect = cs;
        write_n    = wn;
        address    = addr;
        writedata  = data;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b1, address, 32'd0);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        idleCycles(2);
        reset_n = 1'b1;
    endtask

    initial begin
        int exp_seq[4];
        logic [31:0] r;
        exp_seq = '{1, 2, 0, 1};

        #1 reset_n = 1'b0;
        @(posedge clk); #1;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            checkOutput("reset_readdata", readdata, 32'd0);
        end
        checkOutput("reset_m_chipselect", 32'(m_chipselect), 32'd0);
        checkOutput("reset_m_write_n", 32'(m_write_n), 32'd1);
        checkOutput("reset_cur_sel", 32'(cur_sel), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        $display("[TB] manual go with selector 5");
        applyStimulus(1'b1, 1'b0, ADDR_CTRL, 32'h0000_0502);
        checkOutput("go_accept_cs", 32'(m_chipselect), 32'd0);
        checkOutput("go_accept_busy", 32'(busy), 32'd1);
        idleCycles(1);
        checkOutput("go_strobe_cs", 32'(m_chipselect), 32'd1);
        checkOutput("go_strobe_wn", 32'(m_write_n), 32'd0);
        checkOutput("go_strobe_data", m_writedata, 32'h5);
        idleCycles(1);
        checkOutput("go_done_cs", 32'(m_chipselect), 32'd0);
        checkOutput("go_cur_sel", 32'(cur_sel), 32'h5);
        address = ADDR_STATUS; #1;
        checkOutput("go_status", readdata, 32'h0000_0500);
        address = ADDR_CTRL; #1;
        checkOutput("go_ctrl_readback", readdata, 32'h0000_0500);

        $display("[TB] periodic scan, PERIOD=4 SCAN_MAX=2");
        doReset();
        applyStimulus(1'b1, 1'b0, ADDR_PERIOD, 32'd4);
        applyStimulus(1'b1, 1'b0, ADDR_SCAN_MAX, 32'd2);
        strobe_data.delete(); strobe_cyc.delete();
        applyStimulus(1'b1, 1'b0, ADDR_CTRL, 32'h1);
        idleCycles(20);
        checkOutput("scan_strobe_count_ge4", 32'(strobe_data.size() >= 4), 32'd1);
        if (strobe_data.size() >= 4) begin
            for (int i = 0; i < 4; i++) checkOutput("scan_data", strobe_data[i], 32'(exp_seq[i]));
            for (int i = 0; i < 3; i++) checkOutput("scan_gap", 32'(strobe_cyc[i+1] - strobe_cyc[i]), 32'd4);
        end

        $display("[TB] scan tick coincident with manual go");
        doReset();
        applyStimulus(1'b1, 1'b0, ADDR_PERIOD, 32'd4);
        applyStimulus(1'b1, 1'b0, ADDR_SCAN_MAX, 32'd10);
        applyStimulus(1'b1, 1'b0, ADDR_CTRL, 32'h1);
        idleCycles(3);
        applyStimulus(1'b1, 1'b0, ADDR_CTRL, 32'h0000_0703);
        checkOutput("coinc_accept_busy", 32'(busy), 32'd1);
        idleCycles(1);
        checkOutput("coinc_manual_cs", 32'(m_chipselect), 32'd1);
        checkOutput("coinc_manual_data", m_writedata, 32'h7);
        idleCycles(1);
        checkOutput("coinc_gap_cs", 32'(m_chipselect), 32'd0);
        checkOutput("coinc_gap_busy", 32'(busy), 32'd1);
        checkOutput("coinc_cur_sel", 32'(cur_sel), 32'h7);
        idleCycles(1);
        checkOutput("coinc_scan_cs", 32'(m_chipselect), 32'd1);
        checkOutput("coinc_scan_data", m_writedata, 32'h8);

        $display("[TB] clear scan_en one cycle before tick");
        doReset();
        applyStimulus(1'b1, 1'b0, ADDR_PERIOD, 32'd4);
        applyStimulus(1'b1, 1'b0, ADDR_CTRL, 32'h1);
        idleCycles(2);
        strobe_data.delete();
        applyStimulus(1'b1, 1'b0, ADDR_CTRL, 32'h0);
        checkOutput("disable_busy", 32'(busy), 32'd0);
        idleCycles(10);
        checkOutput("disable_no_strobe", 32'(strobe_data.size()), 32'd0);

        $display("[TB] reset during strobe");
        doReset();
        applyStimulus(1'b1, 1'b0, ADDR_CTRL, 32'h0000_0902);
        idleCycles(1);
        checkOutput("abort_strobe_cs", 32'(m_chipselect), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("abort_async_cs", 32'(m_chipselect), 32'd0);
        checkOutput("abort_async_wn", 32'(m_write_n), 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        strobe_data.delete();
        idleCycles(6);
        checkOutput("abort_no_resume", 32'(strobe_data.size()), 32'd0);

        $display("[TB] randomised traffic");
        doReset();
        for (int i = 0; i < 3000; i++) begin
            int sel;
            sel = $urandom_range(0, 99);
            r = $urandom;
            if (sel < 8)
                applyStimulus(1'b1, 1'b0, ADDR_CTRL,
                              {16'd0, 4'd0, 4'($urandom_range(0, 15)), 6'd0,
                               1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)});
            else if (sel < 12)
                applyStimulus(1'b1, 1'b0, ADDR_PERIOD, 32'($urandom_range(0, 6)));
            else if (sel < 16)
                applyStimulus(1'b1, 1'b0, ADDR_SCAN_MAX, (r & 32'hFFFF_FF00) | 32'($urandom_range(0, 12)));
            else if (sel < 18)
                applyStimulus(1'b1, 1'b0, ADDR_STATUS, r);
            else if (sel < 20)
                applyStimulus(1'b0, 1'b0, 2'($urandom_range(0, 3)), r);
            else if (sel < 21)
                doReset();
            else
                applyStimulus(1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3)), r);
        end
        idleCycles(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
